// File: rtl/ram_frame_writer.sv
// Ping-pong frame writer: packs a valid/ready word stream into two RAM banks and
// hands complete frames to a consumer via bank_full/lenX, releasing on bank_release.
module ram_frame_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dia,
  output logic [1:0]        bank_full,
  output logic [ADDR_W-1:0] len0,
  output logic [ADDR_W-1:0] len1,
  input  logic [1:0]        bank_release,
  output logic              trunc
);

  localparam int OFF_W = ADDR_W - 1;
  localparam logic [OFF_W-1:0]  OFF_MAX = '1;
  localparam logic [OFF_W-1:0]  OFF_ONE = 1;
  localparam logic [ADDR_W-1:0] LEN_ONE = 1;

  typedef enum logic {FILL = 1'b0, WAIT = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ready_nxt;
  logic              wbank;
  logic [OFF_W-1:0]  offset;
  logic              accept;
  logic              close;
  logic [1:0]        set_pend;
  logic [ADDR_W-1:0] len_pend;
  logic [1:0]        full_eff;

  assign accept = s_valid & s_ready;
  assign close  = accept & (s_last | (offset == OFF_MAX));
  // A bank whose full flag lands next edge is already owned by the consumer.
  assign full_eff = bank_full | set_pend;

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (close && full_eff[!wbank]) state_nxt = WAIT;
      WAIT:    if (!full_eff[wbank])          state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_comb begin
    ready_nxt = (state_nxt == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready <= 1'b0;
      wbank   <= 1'b0;
      offset  <= '0;
      wea     <= 1'b0;
      addra   <= '0;
      dia     <= '0;
      trunc   <= 1'b0;
    end else begin
      s_ready <= ready_nxt;
      wea     <= accept;
      trunc   <= close & ~s_last;
      if (accept) begin
        addra <= {wbank, offset};
        dia   <= s_data;
        if (close) begin
          wbank  <= ~wbank;
          offset <= '0;
        end else begin
          offset <= offset + OFF_ONE;
        end
      end
    end
  end

  // Frame hand-off trails the final write strobe by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      set_pend  <= 2'b00;
      len_pend  <= '0;
      bank_full <= 2'b00;
      len0      <= '0;
      len1      <= '0;
    end else begin
      set_pend  <= close ? (wbank ? 2'b10 : 2'b01) : 2'b00;
      if (close) len_pend <= {1'b0, offset} + LEN_ONE;
      bank_full <= (bank_full & ~bank_release) | set_pend;
      if (set_pend[0]) len0 <= len_pend;
      if (set_pend[1]) len1 <= len_pend;
    end
  end

endmodule

// File: tb/tb_ram_frame_writer.sv
// Bench for ram_frame_writer: directed scenarios plus randomized frames, with a
// queue-based reference model and an independent monitor checking writes and lengths.
module tb_ram_frame_writer;

  localparam int DW  = 16;
  localparam int AW  = 6;
  localparam int CAP = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          s_ready, wea, trunc;
  logic [AW-1:0] addra, len0, len1;
  logic [DW-1:0] dia;
  logic [1:0]    bank_full;
  logic [1:0]    dir_rel = 2'b00;
  logic [1:0]    cons_rel = 2'b00;

  always #5 clk = ~clk;

  ram_frame_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .wea(wea), .addra(addra), .dia(dia), .bank_full(bank_full),
    .len0(len0), .len1(len1), .bank_release(dir_rel | cons_rel), .trunc(trunc)
  );

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct packed { logic bank; logic [AW-1:0] len; } ev_t;

  wr_t  wq[$];
  ev_t  lq[$];
  wr_t  we;
  ev_t  le;
  int   tests = 0;
  int   fails = 0;
  int   m_off = 0;
  bit   m_bank = 1'b0;
  int   trunc_exp = 0;
  int   trunc_seen = 0;
  bit   mon_en = 1'b0;
  bit   cons_en = 1'b0;
  logic [1:0] prev_bf = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: frames close on s_last or after CAP words; banks alternate.
  task automatic model_beat(input logic [DW-1:0] d, input bit last);
    wq.push_back('{addr: AW'(m_bank * CAP + m_off), data: d});
    if (last || m_off == CAP - 1) begin
      lq.push_back('{bank: m_bank, len: AW'(m_off + 1)});
      if (!last) trunc_exp++;
      m_bank = !m_bank;
      m_off  = 0;
    end else begin
      m_off++;
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) to_pos();
  endtask

  task automatic beat(input logic [DW-1:0] d, input bit last);
    int t = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    do begin
      @(negedge clk);
      t++;
    end while (s_ready !== 1'b1 && t < 300);
    if (s_ready !== 1'b1) chk("accept_timeout", {31'b0, s_ready}, 32'd1);
    else                  model_beat(d, last);
    to_pos();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    dir_rel = 2'b00;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    wq.delete();
    lq.delete();
    m_off = 0;
    m_bank = 1'b0;
    trunc_exp = 0;
    trunc_seen = 0;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (wea === 1'b1) begin
        if (wq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write: addra 0x%0h dia 0x%0h, required no write", addra, dia);
        end else begin
          we = wq.pop_front();
          chk("write_addra", addra, we.addr);
          chk("write_dia", dia, we.data);
        end
      end
      if (trunc === 1'b1) trunc_seen++;
      for (int b = 0; b < 2; b++) begin
        if (bank_full[b] === 1'b1 && prev_bf[b] !== 1'b1) begin
          if (lq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_full: bank %0d set, required no frame", b);
          end else begin
            le = lq.pop_front();
            chk("full_bank", b, le.bank);
            chk("frame_len", (b == 1) ? len1 : len0, le.len);
          end
        end
      end
      prev_bf = bank_full;
    end
  end

  // Random consumer: frees full banks after a random hold.
  initial begin
    forever begin
      to_pos();
      cons_rel = 2'b00;
      if (cons_en)
        for (int b = 0; b < 2; b++)
          if (bank_full[b] === 1'b1 && $urandom_range(0, 2) == 0) cons_rel[b] = 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    int flen, t;
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_wea", wea, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dia", dia, 0);
    chk("rst_bank_full", bank_full, 0);
    chk("rst_len0", len0, 0);
    chk("rst_len1", len1, 0);
    chk("rst_trunc", trunc, 0);
    mon_en = 1'b1;
    to_pos();
    rst = 1'b0;
    to_pos();
    @(negedge clk);
    chk("ready_after_rst", s_ready, 1);
    to_pos();

    // Single 4-word frame
    for (int i = 0; i < 4; i++) beat(16'hA000 + 16'(i), i == 3);
    @(negedge clk);
    chk("single_full_early", bank_full, 2'b00);
    @(negedge clk);
    chk("single_full", bank_full, 2'b01);
    chk("single_len0", len0, 4);
    to_pos();
    idle(2);

    // Ping-pong backpressure
    do_reset(2);
    for (int i = 0; i < 3; i++) beat(16'hB000 + 16'(i), i == 2);
    for (int i = 0; i < 5; i++) beat(16'hC000 + 16'(i), i == 4);
    idle(3);
    @(negedge clk);
    chk("pp_full", bank_full, 2'b11);
    chk("pp_len0", len0, 3);
    chk("pp_len1", len1, 5);
    chk("pp_wait_ready", s_ready, 0);
    to_pos();
    dir_rel = 2'b01;
    @(negedge clk);
    chk("pp_full_hold", bank_full, 2'b11);
    to_pos();
    dir_rel = 2'b00;
    @(negedge clk);
    chk("pp_full_rel", bank_full, 2'b10);
    chk("pp_ready_lag", s_ready, 0);
    to_pos();
    @(negedge clk);
    chk("pp_ready_back", s_ready, 1);
    to_pos();
    beat(16'hD000, 1'b1);
    @(negedge clk);
    chk("pp_next_wea", wea, 1);
    chk("pp_next_addra", addra, 0);
    to_pos();
    idle(3);
    dir_rel = 2'b11;
    to_pos();
    dir_rel = 2'b00;
    idle(3);

    // Truncation at capacity
    do_reset(2);
    for (int i = 0; i < 33; i++) beat(16'hE000 + 16'(i), 1'b0);
    idle(3);
    @(negedge clk);
    chk("trunc_count", trunc_seen, 1);
    chk("trunc_len0", len0, 32);
    chk("trunc_full", bank_full, 2'b01);
    to_pos();

    // Release of an empty bank, then coincident set/release on bank 1
    do_reset(2);
    dir_rel = 2'b01;
    to_pos();
    dir_rel = 2'b00;
    @(negedge clk);
    chk("empty_release", bank_full, 2'b00);
    to_pos();
    beat(16'hF000, 1'b1);
    beat(16'hF001, 1'b1);
    dir_rel = 2'b10;
    to_pos();
    dir_rel = 2'b00;
    @(negedge clk);
    chk("coinc_full", bank_full, 2'b11);
    to_pos();
    @(negedge clk);
    chk("coinc_hold", bank_full[1], 1);
    chk("coinc_len1", len1, 1);
    chk("coinc_len0", len0, 1);
    to_pos();
    dir_rel = 2'b11;
    to_pos();
    dir_rel = 2'b00;
    @(negedge clk);
    chk("both_release", bank_full, 2'b00);
    to_pos();

    // Reset mid-frame
    do_reset(2);
    idle(1);
    beat(16'h1110, 1'b0);
    beat(16'h1111, 1'b0);
    s_valid = 1'b1;
    s_data  = 16'h1112;
    do_reset(1);
    s_valid = 1'b0;
    @(negedge clk);
    chk("midrst_wea", wea, 0);
    chk("midrst_full", bank_full, 2'b00);
    to_pos();
    beat(16'h2220, 1'b0);
    @(negedge clk);
    chk("midrst_addra", addra, 0);
    to_pos();
    beat(16'h2221, 1'b1);
    idle(4);
    chk("midrst_len0", len0, 2);

    // Randomized frames with gaps and a random consumer
    do_reset(2);
    cons_en = 1'b1;
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: flen = 1;
        3:       flen = 33 + int'($urandom_range(0, 7));
        default: flen = 2 + int'($urandom_range(0, 10));
      endcase
      for (int i = 0; i < flen; i++) begin
        idle(int'($urandom_range(0, 2)));
        beat(DW'($urandom), i == flen - 1);
      end
    end
    t = 0;
    while ((wq.size() != 0 || lq.size() != 0) && t < 500) begin
      to_pos();
      t++;
    end
    idle(2);
    chk("drain_writes", wq.size(), 0);
    chk("drain_frames", lq.size(), 0);
    chk("rand_trunc", trunc_seen, trunc_exp);
    cons_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
